// File: rtl/stream_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// stream_frame_receiver_if
// Purpose : 64-bit AXI-Stream style bundle shared by the frame receiver's
//           input (slave) and payload output (master) sides.
// Signals : tdata  [63:0]  data word
//           tvalid          producer has a word
//           tready          consumer can take the word
//           tlast           end-of-packet marker
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
// ---------------------------------------------------------------------------
interface stream_frame_receiver_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_frame_receiver.sv
// ---------------------------------------------------------------------------
// stream_frame_receiver
// Purpose : AXI-Stream sink for acquisition frames (MAGIC, 64-bit timestamp,
//           DATA_WORDS payload words, TLAST on the last one). Checks framing
//           and timestamp continuity, forwards payload words through a
//           single output register and keeps saturating status counters.
// Ports   : clk, rst         clock, synchronous active-high reset
//           rx_enable        0 discards input and returns to HUNT
//           clear_counters   single-cycle pulse zeroing all counters
//           s_axis           frame input (slave)
//           m_axis           payload output (master)
//           frame_done       pulse the cycle after a good frame ends
//           last_timestamp   timestamp of the most recent good frame
//           frames_ok, sync_err, len_err, ts_gap_err  status counters
//           rx_busy          receiver is inside a frame (not HUNT)
// ---------------------------------------------------------------------------
module stream_frame_receiver #(
    parameter logic [63:0] MAGIC_NUMBER = 64'hDEADBEEFCAFEBABE,
    parameter int          DATA_WORDS   = 35,
    parameter int          CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_enable,
    input  logic                    clear_counters,
    stream_frame_receiver_if.slave  s_axis,
    stream_frame_receiver_if.master m_axis,
    output logic                    frame_done,
    output logic [63:0]             last_timestamp,
    output logic [CNT_W-1:0]        frames_ok,
    output logic [CNT_W-1:0]        sync_err,
    output logic [CNT_W-1:0]        len_err,
    output logic [CNT_W-1:0]        ts_gap_err,
    output logic                    rx_busy
);

    localparam int            CW       = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WORDS - 1);

    typedef enum logic [1:0] {ST_HUNT, ST_TS, ST_DATA, ST_DROP} state_t;

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic             r_sync_flag, w_sync_flag_next;
    logic             r_ts_valid;
    logic [63:0]      r_cand_ts;
    logic [63:0]      r_last_ts;
    logic [CNT_W-1:0] r_frames_ok, r_sync_err, r_len_err, r_ts_gap_err;
    logic             r_frame_done;
    logic [63:0]      r_m_tdata;
    logic             r_m_tvalid;
    logic             r_m_tlast;

    logic w_s_tready, w_beat, w_inc_sync, w_inc_len, w_good, w_gap;
    logic w_fwd, w_fwd_last, w_load_ts;

    // Saturating counter step; a clear on the same cycle always wins.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                              input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (v != '1))
            return v + CNT_W'(1);
        return v;
    endfunction

    // Input is only back-pressured while a payload word waits for the output
    // register; everywhere else (and while disabled) words are swallowed.
    always_comb begin
        w_s_tready = 1'b1;
        if (rx_enable && (r_state == ST_DATA))
            w_s_tready = !r_m_tvalid || m_axis.tready;
    end

    assign w_beat = s_axis.tvalid && w_s_tready && rx_enable;
    assign w_gap  = r_ts_valid && (r_cand_ts != r_last_ts + 64'd1);

    // Frame parser: next state plus single-cycle event strobes.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_sync_flag_next = r_sync_flag;
        w_inc_sync       = 1'b0;
        w_inc_len        = 1'b0;
        w_good           = 1'b0;
        w_fwd            = 1'b0;
        w_fwd_last       = 1'b0;
        w_load_ts        = 1'b0;
        if (!rx_enable) begin
            w_state_next     = ST_HUNT;
            w_cnt_next       = '0;
            w_sync_flag_next = 1'b0;
        end else if (w_beat) begin
            case (r_state)
                ST_HUNT: begin
                    if (s_axis.tdata == MAGIC_NUMBER) begin
                        w_sync_flag_next = 1'b0;
                        if (s_axis.tlast)
                            w_inc_len = 1'b1;
                        else
                            w_state_next = ST_TS;
                    end else if (!r_sync_flag) begin
                        // Only the first bad word of a run is counted.
                        w_inc_sync       = 1'b1;
                        w_sync_flag_next = 1'b1;
                    end
                end
                ST_TS: begin
                    w_load_ts = 1'b1;
                    if (s_axis.tlast) begin
                        w_inc_len    = 1'b1;
                        w_state_next = ST_HUNT;
                    end else begin
                        w_cnt_next   = '0;
                        w_state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_fwd      = 1'b1;
                    w_cnt_next = r_cnt + CW'(1);
                    if (s_axis.tlast) begin
                        w_state_next = ST_HUNT;
                        if (r_cnt == LAST_IDX) begin
                            w_good     = 1'b1;
                            w_fwd_last = 1'b1;
                        end else begin
                            w_inc_len = 1'b1;
                        end
                    end else if (r_cnt == LAST_IDX) begin
                        // Overlong frame: close the payload packet, drop the rest.
                        w_fwd_last   = 1'b1;
                        w_inc_len    = 1'b1;
                        w_state_next = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_axis.tlast)
                        w_state_next = ST_HUNT;
                end
                default: w_state_next = ST_HUNT;
            endcase
        end
    end

    // State, timestamp tracking, counters and the payload output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_cnt        <= '0;
            r_sync_flag  <= 1'b0;
            r_ts_valid   <= 1'b0;
            r_cand_ts    <= '0;
            r_last_ts    <= '0;
            r_frames_ok  <= '0;
            r_sync_err   <= '0;
            r_len_err    <= '0;
            r_ts_gap_err <= '0;
            r_frame_done <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_sync_flag  <= w_sync_flag_next;
            r_frame_done <= w_good;
            if (w_load_ts)
                r_cand_ts <= s_axis.tdata;
            if (!rx_enable)
                r_ts_valid <= 1'b0;
            else if (w_good)
                r_ts_valid <= 1'b1;
            if (w_good)
                r_last_ts <= r_cand_ts;
            r_frames_ok  <= bump(r_frames_ok, w_good, clear_counters);
            r_sync_err   <= bump(r_sync_err, w_inc_sync, clear_counters);
            r_len_err    <= bump(r_len_err, w_inc_len, clear_counters);
            r_ts_gap_err <= bump(r_ts_gap_err, w_good && w_gap, clear_counters);
            // A word is only accepted when the register is free or draining.
            if (w_fwd) begin
                r_m_tdata  <= s_axis.tdata;
                r_m_tlast  <= w_fwd_last;
                r_m_tvalid <= 1'b1;
            end else if (m_axis.tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis.tready  = w_s_tready;
    assign m_axis.tdata   = r_m_tdata;
    assign m_axis.tvalid  = r_m_tvalid;
    assign m_axis.tlast   = r_m_tlast;
    assign frame_done     = r_frame_done;
    assign last_timestamp = r_last_ts;
    assign frames_ok      = r_frames_ok;
    assign sync_err       = r_sync_err;
    assign len_err        = r_len_err;
    assign ts_gap_err     = r_ts_gap_err;
    assign rx_busy        = (r_state != ST_HUNT);

endmodule

// File: tb/tb_stream_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_stream_frame_receiver
// Purpose : self-checking bench for stream_frame_receiver. A frame-level
//           model predicts forwarded payload words and counter values; a
//           negedge monitor compares every output beat against it.
// ---------------------------------------------------------------------------
module tb_stream_frame_receiver;

    localparam logic [63:0] MAGIC   = 64'hDEADBEEFCAFEBABE;
    localparam int          DW      = 35;
    localparam int          CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_enable;
    logic        clear_counters;
    logic        frame_done;
    logic [63:0] last_timestamp;
    logic [15:0] frames_ok, sync_err, len_err, ts_gap_err;
    logic        rx_busy;

    stream_frame_receiver_if s_if ();
    stream_frame_receiver_if m_if ();

    stream_frame_receiver #(
        .MAGIC_NUMBER (MAGIC),
        .DATA_WORDS   (DW),
        .CNT_W        (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_enable      (rx_enable),
        .clear_counters (clear_counters),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .frame_done     (frame_done),
        .last_timestamp (last_timestamp),
        .frames_ok      (frames_ok),
        .sync_err       (sync_err),
        .len_err        (len_err),
        .ts_gap_err     (ts_gap_err),
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    int          checks = 0;
    int          passes = 0;
    beat_t       expQ[$];
    int          mOk = 0, mSync = 0, mLen = 0, mGap = 0, mFd = 0;
    logic [63:0] mLastTs = '0;
    bit          mTsValid = 1'b0;
    bit          mInRun = 1'b0;
    int          obsFd = 0, obsBeats = 0, obsTlast = 0;
    logic [63:0] obsTlastData = '0;
    int          readyMode = 0;
    int          cyc = 0;
    bit          prevStall = 1'b0;
    logic [63:0] prevData;
    logic        prevLast;

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Downstream ready pattern: always ready, or ready one cycle in three.
    always @(posedge clk) begin
        #1;
        cyc++;
        m_if.tready = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Output monitor: every handshake is matched against the model queue,
    // and a stalled word must stay put until it is taken.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("m_stall_valid", 64'(m_if.tvalid), 64'd1);
                checkOutput("m_stall_data", m_if.tdata, prevData);
                checkOutput("m_stall_last", 64'(m_if.tlast), 64'(prevLast));
            end
            if (m_if.tvalid && m_if.tready) begin
                beat_t e;
                obsBeats++;
                if (m_if.tlast) begin
                    obsTlast++;
                    obsTlastData = m_if.tdata;
                end
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL m_unexpected_beat: got 0x%0h, expected no beat", m_if.tdata);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("m_tdata", m_if.tdata, e.data);
                    checkOutput("m_tlast", 64'(m_if.tlast), 64'(e.last));
                end
            end
            if (frame_done)
                obsFd++;
            prevStall = m_if.tvalid && !m_if.tready;
            prevData  = m_if.tdata;
            prevLast  = m_if.tlast;
        end
    end

    // Present one input word and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [63:0] d, input logic l);
        bit acc;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            if (acc) begin
                s_if.tvalid = 1'b0;
                return;
            end
        end
        checks++;
        $display("[TB] FAIL s_accept_timeout: got no tready, expected accept of 0x%0h", d);
        s_if.tvalid = 1'b0;
    endtask

    // Send MAGIC, timestamp and nPay payload words with tlast on the final one.
    task automatic sendFrame(input logic [63:0] ts, input int nPay, input bit clearOnLast);
        beat_t b;
        bit    l;
        mInRun = 1'b0;
        applyStimulus(MAGIC, 1'b0);
        applyStimulus(ts, 1'b0);
        for (int i = 0; i < nPay; i++) begin
            l = (i == nPay - 1);
            if (clearOnLast && l)
                clear_counters = 1'b1;
            applyStimulus(64'h1000 + 64'(i), l);
            clear_counters = 1'b0;
            if (i < DW) begin
                b.data = 64'h1000 + 64'(i);
                b.last = (i == DW - 1);
                expQ.push_back(b);
            end
        end
        if (nPay == DW) begin
            if (mTsValid && (ts != mLastTs + 64'd1))
                mGap = sat(mGap);
            mOk      = sat(mOk);
            mLastTs  = ts;
            mTsValid = 1'b1;
            mFd++;
        end else begin
            mLen = sat(mLen);
        end
        if (clearOnLast) begin
            mOk = 0; mSync = 0; mLen = 0; mGap = 0;
        end
    endtask

    task automatic sendGarbage(input logic [63:0] d);
        applyStimulus(d, 1'b0);
        if (!mInRun) begin
            mSync  = sat(mSync);
            mInRun = 1'b1;
        end
    endtask

    task automatic clearCounters();
        clear_counters = 1'b1;
        @(posedge clk); #1;
        clear_counters = 1'b0;
        mOk = 0; mSync = 0; mLen = 0; mGap = 0;
    endtask

    task automatic pulseDisable();
        rx_enable = 1'b0;
        @(posedge clk); #1;
        rx_enable = 1'b1;
        mTsValid = 1'b0;
        mInRun   = 1'b0;
    endtask

    // Let the output drain, then compare status outputs against the model.
    task automatic checkModel(input string label);
        bit drained = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (expQ.size() == 0 && !m_if.tvalid) begin
                drained = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput({label, ".drained"}, 64'(drained), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({label, ".frames_ok"}, 64'(frames_ok), 64'(mOk));
        checkOutput({label, ".sync_err"}, 64'(sync_err), 64'(mSync));
        checkOutput({label, ".len_err"}, 64'(len_err), 64'(mLen));
        checkOutput({label, ".ts_gap_err"}, 64'(ts_gap_err), 64'(mGap));
        checkOutput({label, ".last_timestamp"}, last_timestamp, mLastTs);
        checkOutput({label, ".frame_done_count"}, 64'(obsFd), 64'(mFd));
        checkOutput({label, ".rx_busy"}, 64'(rx_busy), 64'd0);
    endtask

    task automatic checkAllZero(input string label);
        checkOutput({label, ".m_tvalid"}, 64'(m_if.tvalid), 64'd0);
        checkOutput({label, ".frames_ok"}, 64'(frames_ok), 64'd0);
        checkOutput({label, ".sync_err"}, 64'(sync_err), 64'd0);
        checkOutput({label, ".len_err"}, 64'(len_err), 64'd0);
        checkOutput({label, ".ts_gap_err"}, 64'(ts_gap_err), 64'd0);
        checkOutput({label, ".last_timestamp"}, last_timestamp, 64'd0);
        checkOutput({label, ".frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({label, ".rx_busy"}, 64'(rx_busy), 64'd0);
        checkOutput({label, ".s_tready"}, 64'(s_if.tready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        rx_enable      = 1'b1;
        clear_counters = 1'b0;
        s_if.tvalid    = 1'b0;
        s_if.tdata     = '0;
        s_if.tlast     = 1'b0;
        m_if.tready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single good frame.
        obsBeats = 0; obsTlast = 0;
        sendFrame(64'd5, DW, 1'b0);
        checkModel("t1");
        checkOutput("t1.lit_frames_ok", 64'(frames_ok), 64'd1);
        checkOutput("t1.lit_last_ts", last_timestamp, 64'd5);
        checkOutput("t1.lit_frame_done", 64'(obsFd), 64'd1);
        checkOutput("t1.lit_beats", 64'(obsBeats), 64'd35);
        checkOutput("t1.lit_tlast_count", 64'(obsTlast), 64'd1);
        checkOutput("t1.lit_tlast_data", obsTlastData, 64'h1022);

        // Timestamp continuity.
        pulseDisable();
        clearCounters();
        sendFrame(64'd7, DW, 1'b0);
        sendFrame(64'd9, DW, 1'b0);
        checkModel("t2a");
        checkOutput("t2a.lit_frames_ok", 64'(frames_ok), 64'd2);
        checkOutput("t2a.lit_ts_gap", 64'(ts_gap_err), 64'd1);
        sendFrame(64'd10, DW, 1'b0);
        checkModel("t2b");
        checkOutput("t2b.lit_ts_gap", 64'(ts_gap_err), 64'd1);
        checkOutput("t2b.lit_last_ts", last_timestamp, 64'd10);

        // Garbage run before a frame.
        pulseDisable();
        clearCounters();
        sendGarbage(64'h1);
        sendGarbage(64'h2);
        sendGarbage(64'h3);
        sendFrame(64'd20, DW, 1'b0);
        checkModel("t3");
        checkOutput("t3.lit_sync_err", 64'(sync_err), 64'd1);
        checkOutput("t3.lit_frames_ok", 64'(frames_ok), 64'd1);

        // Short frame, long frame, then a good one.
        clearCounters();
        obsBeats = 0; obsTlast = 0;
        sendFrame(64'd30, 11, 1'b0);
        checkModel("t4a");
        checkOutput("t4a.lit_len_err", 64'(len_err), 64'd1);
        checkOutput("t4a.lit_beats", 64'(obsBeats), 64'd11);
        checkOutput("t4a.lit_tlast_count", 64'(obsTlast), 64'd0);
        obsBeats = 0;
        sendFrame(64'd31, 40, 1'b0);
        checkModel("t4b");
        checkOutput("t4b.lit_len_err", 64'(len_err), 64'd2);
        checkOutput("t4b.lit_beats", 64'(obsBeats), 64'd35);
        checkOutput("t4b.lit_tlast_count", 64'(obsTlast), 64'd1);
        sendFrame(64'd32, DW, 1'b0);
        checkModel("t4c");
        checkOutput("t4c.lit_frames_ok", 64'(frames_ok), 64'd1);

        // Downstream back-pressure.
        clearCounters();
        readyMode = 1;
        sendFrame(64'd33, DW, 1'b0);
        checkModel("t5");
        readyMode = 0;
        checkOutput("t5.lit_frames_ok", 64'(frames_ok), 64'd1);
        checkOutput("t5.lit_ts_gap", 64'(ts_gap_err), 64'd0);

        // Reset in the middle of a payload.
        clearCounters();
        applyStimulus(MAGIC, 1'b0);
        applyStimulus(64'd50, 1'b0);
        for (int i = 0; i < 10; i++) begin
            beat_t b;
            applyStimulus(64'h2000 + 64'(i), 1'b0);
            b.data = 64'h2000 + 64'(i);
            b.last = 1'b0;
            expQ.push_back(b);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        expQ.delete();
        mOk = 0; mSync = 0; mLen = 0; mGap = 0;
        mLastTs = '0; mTsValid = 1'b0; mInRun = 1'b0;
        @(posedge clk); #1;
        checkAllZero("t6.rst");
        rst = 1'b0;
        @(posedge clk); #1;
        sendFrame(64'd100, DW, 1'b0);
        checkModel("t6a");
        checkOutput("t6a.lit_frames_ok", 64'(frames_ok), 64'd1);
        checkOutput("t6a.lit_ts_gap", 64'(ts_gap_err), 64'd0);
        sendFrame(64'd101, DW, 1'b1);
        checkModel("t6b");
        checkOutput("t6b.lit_frames_ok", 64'(frames_ok), 64'd0);
        checkOutput("t6b.lit_last_ts", last_timestamp, 64'd101);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
